seq_match_window_counter: RTL and testbench



---
 rtl/seq_match_window_counter_if.sv | 27 ++
 rtl/seq_match_window_counter.sv | 131 +++++++++++++
 tb/tb_seq_match_window_counter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_match_window_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_match_window_counter_if
// Description : Result valid/ready port of the match window counter.
//               master = producer of results, slave = consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_match_window_counter_if #(
    parameter int CNT_W = 5
) ();
    logic [CNT_W-1:0] result_count;
    logic             result_valid;
    logic             result_ready;

    modport master (
        output result_count,
        output result_valid,
        input  result_ready
    );

    modport slave (
        input  result_count,
        input  result_valid,
        output result_ready
    );
endinterface
`default_nettype wire

// File: rtl/seq_match_window_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_match_window_counter
// Description : Counts detector match pulses over fixed WINDOW_LEN-cycle
//               windows, publishes each window total on a valid/ready port,
//               pulses an alarm for totals >= THRESHOLD and flags totals
//               dropped because the result slot was still full (sticky).
//               Optional macro SEQ_CNT_SATURATE_EN: accumulator saturates
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_match_window_counter #(
    parameter int WINDOW_LEN = 16,
    parameter int CNT_W      = 5,
    parameter int THRESHOLD  = 4
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  enable,
    input  wire logic                  match_in,
    input  wire logic                  clear_ovr,
    seq_match_window_counter_if.master res,
    output logic                       alarm,
    output logic                       overrun
);

    localparam int               c_WC_W    = $clog2(WINDOW_LEN);
    localparam logic [c_WC_W-1:0] c_LAST   = c_WC_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] c_ACC_MAX = {CNT_W{1'b1}};

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_COUNT = 1'b1;

    logic [0:0]        r_state;
    logic [c_WC_W-1:0] r_win_cnt;
    logic [CNT_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_count;
    logic              r_valid;
    logic              r_alarm;
    logic              r_overrun;

    logic [CNT_W-1:0]  w_acc_next;
    logic              w_win_end;
    logic              w_xfer;
    logic              w_slot_free;
    logic              w_hit;

    // Accumulator including this cycle's match; it is also the window total
    // on the last window cycle.
`ifdef SEQ_CNT_SATURATE_EN
    assign w_acc_next = (r_acc == c_ACC_MAX) ? r_acc : r_acc + CNT_W'(match_in);
`else
    assign w_acc_next = r_acc + CNT_W'(match_in);
`endif

    // A window only completes if enable is still high on its last cycle;
    // otherwise the partial window is discarded on the way to IDLE.
    assign w_win_end   = (r_state == S_COUNT) && enable && (r_win_cnt == c_LAST);
    assign w_xfer      = r_valid && res.result_ready;
    assign w_slot_free = !r_valid || w_xfer;
    assign w_hit       = (32'(w_acc_next) >= $unsigned(THRESHOLD));

    // Window sequencing: IDLE waits for enable, COUNT runs back-to-back windows.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_win_cnt <= '0;
            r_acc     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_win_cnt <= '0;
                    r_acc     <= '0;
                    if (enable) begin
                        r_state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (!enable) begin
                        r_state   <= S_IDLE;
                        r_win_cnt <= '0;
                        r_acc     <= '0;
                    end else if (w_win_end) begin
                        r_win_cnt <= '0;
                        r_acc     <= '0;
                    end else begin
                        r_win_cnt <= r_win_cnt + c_WC_W'(1);
                        r_acc     <= w_acc_next;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_win_cnt <= '0;
                    r_acc     <= '0;
                end
            endcase
        end
    end

    // Result slot, alarm pulse and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_alarm   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_alarm <= 1'b0;
            if (w_win_end && w_slot_free) begin
                r_count <= w_acc_next;
                r_valid <= 1'b1;
                r_alarm <= w_hit;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            // A drop on the same edge as clear_ovr keeps the flag set.
            if (w_win_end && !w_slot_free) begin
                r_overrun <= 1'b1;
            end else if (clear_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign res.result_count = r_count;
    assign res.result_valid = r_valid;
    assign alarm            = r_alarm;
    assign overrun          = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_seq_match_window_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_match_window_counter
// Description : Self-checking bench for seq_match_window_counter
//               (WINDOW_LEN=8, CNT_W=4, THRESHOLD=3, plus a CNT_W=3 instance
//               exercising accumulator overflow).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_match_window_counter;

    localparam int WL  = 8;
    localparam int CW  = 4;
    localparam int THR = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n   = 1'b0;
    logic enable    = 1'b0;
    logic match_in  = 1'b0;
    logic clear_ovr = 1'b0;
    logic alarm, overrun;

    seq_match_window_counter_if #(.CNT_W(CW)) u_if ();

    seq_match_window_counter #(
        .WINDOW_LEN(WL), .CNT_W(CW), .THRESHOLD(THR)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .match_in(match_in),
        .clear_ovr(clear_ovr), .res(u_if), .alarm(alarm), .overrun(overrun)
    );

    // Undersized accumulator instance: 8 matches into 3 bits.
    logic rn2 = 1'b0, en2 = 1'b0, m2 = 1'b1, clr2 = 1'b0;
    logic alarm2, overrun2;
    seq_match_window_counter_if #(.CNT_W(3)) u_if2 ();

    seq_match_window_counter #(
        .WINDOW_LEN(WL), .CNT_W(3), .THRESHOLD(THR)
    ) u_dut2 (
        .clk(clk), .reset_n(rn2), .enable(en2), .match_in(m2),
        .clear_ovr(clr2), .res(u_if2), .alarm(alarm2), .overrun(overrun2)
    );

    int tests  = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window total from the true number of matches, reduced to CW bits.
    function automatic int reduce(input int n, input int w);
        int maxv;
        maxv = (1 << w) - 1;
`ifdef SEQ_CNT_SATURATE_EN
        return (n > maxv) ? maxv : n;
`else
        return n % (1 << w);
`endif
    endfunction

    // ---------------- behavioural reference ----------------
    bit m_run;            // inside a run of windows
    int m_pos;            // cycles already counted in the current window
    int m_matches;        // matches seen so far in the current window
    int m_count;
    bit m_valid, m_alarm, m_ovr;

    always @(posedge clk) begin
        bit xfer, full_drop, end_now;
        int tot;
        if (!reset_n) begin
            m_run <= 0; m_pos <= 0; m_matches <= 0;
            m_count <= 0; m_valid <= 0; m_alarm <= 0; m_ovr <= 0;
        end else begin
            xfer      = m_valid && u_if.result_ready;
            end_now   = m_run && enable && (m_pos == WL - 1);
            full_drop = end_now && m_valid && !xfer;
            m_alarm  <= 0;
            if (end_now && !full_drop) begin
                tot = reduce(m_matches + int'(match_in), CW);
                m_count <= tot;
                m_valid <= 1;
                m_alarm <= (tot >= THR);
            end else if (xfer) begin
                m_valid <= 0;
            end
            if (full_drop)      m_ovr <= 1;
            else if (clear_ovr) m_ovr <= 0;
            if (!m_run || !enable || end_now) begin
                m_run <= enable; m_pos <= 0; m_matches <= 0;
            end else begin
                m_pos <= m_pos + 1;
                m_matches <= m_matches + int'(match_in);
            end
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_count",   int'(u_if.result_count), m_count);
            chk("cyc_valid",   int'(u_if.result_valid), int'(m_valid));
            chk("cyc_alarm",   int'(alarm),             int'(m_alarm));
            chk("cyc_overrun", int'(overrun),           int'(m_ovr));
        end
    end

    task automatic step(input logic rn, input logic en, input logic m,
                        input logic rdy, input logic clr);
        reset_n = rn; enable = en; match_in = m;
        u_if.result_ready = rdy; clear_ovr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_sat;
        u_if.result_ready  = 1'b0;
        u_if2.result_ready = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Overflow instance: enter COUNT, then 8 consecutive matches.
`ifdef SEQ_CNT_SATURATE_EN
        exp_sat = 7;
`else
        exp_sat = 0;
`endif
        rn2 = 1'b1; en2 = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (u_if2.result_valid) break;
        end
        chk("ovf_valid", int'(u_if2.result_valid), 1);
        chk("ovf_count", int'(u_if2.result_count), exp_sat);

        chk_on = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("rst_count", int'(u_if.result_count), 0);
        chk("rst_valid", int'(u_if.result_valid), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_ovr",   int'(overrun), 0);

        // Matches at window cycles 1,4,7 with consumer ready.
        step(1, 1, 0, 1, 0);
        for (int i = 0; i < WL; i++) step(1, 1, (i == 1 || i == 4 || i == 7), 1, 0);
        chk("w1_count", int'(u_if.result_count), 3);
        chk("w1_valid", int'(u_if.result_valid), 1);
        chk("w1_alarm", int'(alarm), 1);
        step(1, 1, 0, 1, 0);
        chk("w1_valid_drop", int'(u_if.result_valid), 0);
        chk("w1_alarm_drop", int'(alarm), 0);

        // Two matches, consumer stalled across the next window end.
        for (int i = 1; i < WL; i++) step(1, 1, (i == 2 || i == 5), 0, 0);
        chk("w2_count", int'(u_if.result_count), 2);
        chk("w2_valid", int'(u_if.result_valid), 1);
        chk("w2_alarm", int'(alarm), 0);
        for (int i = 0; i < WL; i++) step(1, 1, (i < 3), 0, 0);
        chk("w3_count_held", int'(u_if.result_count), 2);
        chk("w3_valid_held", int'(u_if.result_valid), 1);
        chk("w3_overrun",    int'(overrun), 1);
        chk("w3_no_alarm",   int'(alarm), 0);

        // clear_ovr alone, then together with a new drop.
        step(1, 1, 0, 0, 1);
        chk("clr_overrun", int'(overrun), 0);
        for (int i = 1; i < WL - 1; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        chk("clr_vs_drop", int'(overrun), 1);
        chk("clr_count",   int'(u_if.result_count), 2);
        step(1, 1, 0, 1, 0);
        chk("drain_valid", int'(u_if.result_valid), 0);

        // Enable dropped at window cycle 5 after two matches.
        for (int i = 1; i < 5; i++) step(1, 1, (i == 2 || i == 3), 1, 0);
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0);
        chk("abort_no_result", int'(u_if.result_valid), 0);
        step(1, 1, 0, 1, 0);
        for (int i = 0; i < WL; i++) step(1, 1, 0, 1, 0);
        chk("zero_count", int'(u_if.result_count), 0);
        chk("zero_valid", int'(u_if.result_valid), 1);
        chk("zero_alarm", int'(alarm), 0);

        // Reset mid-window with two matches and a pending result.
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("mrst_count", int'(u_if.result_count), 0);
        chk("mrst_valid", int'(u_if.result_valid), 0);
        chk("mrst_ovr",   int'(overrun), 0);
        step(1, 1, 0, 1, 0);
        for (int i = 0; i < WL; i++) step(1, 1, (i < 3), 1, 0);
        chk("fresh_count", int'(u_if.result_count), 3);
        chk("fresh_alarm", int'(alarm), 1);

        // Randomized traffic checked every cycle against the reference.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 19) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0));
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
